// File: rtl/seg_dynamic_scan.sv
// Six-digit common-anode 7-segment driver: serial binary-to-BCD conversion plus 1 ms digit scan.
// Optional anti-ghost blanking after each digit change is enabled by defining SEG_DEGHOST_EN.
module seg_dynamic_scan #(
    parameter int unsigned CNT_1MS_MAX = 49_999,
    parameter int unsigned DATA_W      = 20
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [DATA_W-1:0] data,
    input  logic [5:0]        point,
    input  logic              sign,
    input  logic              seg_en,
    output logic [5:0]        sel,
    output logic [7:0]        seg,
    output logic              conv_done
);

    localparam int unsigned CNT_W   = (CNT_1MS_MAX < 1) ? 1 : $clog2(CNT_1MS_MAX + 1);
    localparam int unsigned BCD_W   = 24;
    localparam int unsigned BITC_W  = 5;
    localparam int unsigned GHOST_W = 5;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_UPDATE} state_t;

    state_t                 state_q, state_d;
    logic [BITC_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]      bin_q, bin_d;
    logic [BCD_W-1:0]       bcd_q, bcd_d, bcd_adj;
    logic                   sign_q, sign_d;
    logic                   ovf_q, ovf_d;
    logic [5:0]             point_q, point_d;
    logic [5:0][7:0]        disp_q, disp_d, disp_new;
    logic                   conv_done_q, conv_done_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [2:0]             idx_q, idx_d;
    logic [5:0]             sel_q, sel_d;
    logic [7:0]             seg_q, seg_d;
    logic [GHOST_W-1:0]     ghost_q, ghost_d;
    logic [2:0]             ms;
    logic                   drive;
    logic                   dwell_end;

    function automatic logic [7:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 8'hC0;
            4'd1:    seg_code = 8'hF9;
            4'd2:    seg_code = 8'hA4;
            4'd3:    seg_code = 8'hB0;
            4'd4:    seg_code = 8'h99;
            4'd5:    seg_code = 8'h92;
            4'd6:    seg_code = 8'h82;
            4'd7:    seg_code = 8'hF8;
            4'd8:    seg_code = 8'h80;
            4'd9:    seg_code = 8'h90;
            default: seg_code = 8'hFF;
        endcase
    endfunction

    // Conversion FSM: capture, 20 shift-and-add-3 steps, publish
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        bin_d       = bin_q;
        bcd_d       = bcd_q;
        sign_d      = sign_q;
        ovf_d       = ovf_q;
        point_d     = point_q;
        disp_d      = disp_q;
        conv_done_d = 1'b0;
        bcd_adj     = bcd_q;
        for (int i = 0; i < 6; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        case (state_q)
            S_IDLE: begin
                bin_d     = data;
                sign_d    = sign;
                point_d   = point;
                ovf_d     = (data > DATA_W'(999_999));
                bcd_d     = '0;
                bit_cnt_d = '0;
                state_d   = S_SHIFT;
            end
            S_SHIFT: begin
                {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
                bit_cnt_d      = bit_cnt_q + BITC_W'(1);
                if (bit_cnt_q == BITC_W'(DATA_W - 1)) state_d = S_UPDATE;
            end
            S_UPDATE: begin
                disp_d      = disp_new;
                conv_done_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Display codes: overflow dashes, leading-zero blanking, minus placement, decimal points
    always_comb begin
        ms       = 3'd0;
        disp_new = '1;
        for (int i = 0; i < 6; i++) begin
            if (bcd_q[4*i +: 4] != 4'd0) ms = 3'(i);
        end
        for (int i = 0; i < 6; i++) begin
            if (ovf_q)                                disp_new[i] = 8'hBF;
            else if (3'(i) <= ms)                     disp_new[i] = seg_code(bcd_q[4*i +: 4]);
            else if (sign_q && (3'(i) == ms + 3'd1))  disp_new[i] = 8'hBF;
            else                                      disp_new[i] = 8'hFF;
            if (point_q[i]) disp_new[i][7] = 1'b0;
        end
    end

    // Digit scan and registered pin drive
    always_comb begin
        dwell_end = (cnt_q == CNT_W'(CNT_1MS_MAX));
        cnt_d     = dwell_end ? '0 : cnt_q + CNT_W'(1);
        idx_d     = idx_q;
        if (dwell_end) idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
        ghost_d   = ghost_q;
`ifdef SEG_DEGHOST_EN
        if (dwell_end)              ghost_d = GHOST_W'(16);
        else if (ghost_q != '0)     ghost_d = ghost_q - GHOST_W'(1);
        drive     = seg_en && (ghost_q == '0);
`else
        drive     = seg_en;
`endif
        sel_d     = 6'h3F;
        seg_d     = 8'hFF;
        if (drive) begin
            sel_d = ~(6'b1 << idx_q);
            seg_d = disp_q[idx_q];
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            bin_q       <= '0;
            bcd_q       <= '0;
            sign_q      <= 1'b0;
            ovf_q       <= 1'b0;
            point_q     <= '0;
            disp_q      <= '1;
            conv_done_q <= 1'b0;
            cnt_q       <= '0;
            idx_q       <= '0;
            ghost_q     <= '0;
            sel_q       <= 6'h3F;
            seg_q       <= 8'hFF;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            bin_q       <= bin_d;
            bcd_q       <= bcd_d;
            sign_q      <= sign_d;
            ovf_q       <= ovf_d;
            point_q     <= point_d;
            disp_q      <= disp_d;
            conv_done_q <= conv_done_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            ghost_q     <= ghost_d;
            sel_q       <= sel_d;
            seg_q       <= seg_d;
        end
    end

    assign sel       = sel_q;
    assign seg       = seg_q;
    assign conv_done = conv_done_q;

endmodule

// File: tb/tb_seg_dynamic_scan.sv
// Randomized bench for seg_dynamic_scan against a cycle-count/decimal-arithmetic reference model.
module tb_seg_dynamic_scan;

    localparam int unsigned CNT_MAX = 9;
    localparam int          DWELL   = CNT_MAX + 1;
    localparam int          PERIOD  = 22;

    typedef logic [5:0][7:0] disp_t;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [19:0] data;
    logic [5:0]  point;
    logic        sign;
    logic        seg_en;
    logic [5:0]  sel;
    logic [7:0]  seg;
    logic        conv_done;

    int          n_cmp = 0;
    int          n_err = 0;
    int          k;
    logic [19:0] cap_d;
    logic        cap_s;
    logic [5:0]  cap_p;
    disp_t       disp_m;

    logic [7:0] code_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    int         lim_tab  [7]  = '{9, 99, 999, 9999, 99999, 999999, 1048575};

    seg_dynamic_scan #(.CNT_1MS_MAX(CNT_MAX), .DATA_W(20)) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .data      (data),
        .point     (point),
        .sign      (sign),
        .seg_en    (seg_en),
        .sel       (sel),
        .seg       (seg),
        .conv_done (conv_done)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (k=%0d data=%0d sign=%0b point=%0h)",
                     tag, obs, exp, k, cap_d, cap_s, cap_p);
        end
    endtask

    function automatic disp_t build(input logic [19:0] d, input logic s, input logic [5:0] p);
        disp_t o;
        int    v;
        int    n;
        int    dig [6];
        if (32'(d) > 32'd999999) begin
            for (int i = 0; i < 6; i++) o[i] = 8'hBF;
        end else begin
            v = 32'(d);
            n = 1;
            for (int i = 0; i < 6; i++) begin
                dig[i] = v % 10;
                v      = v / 10;
                if (dig[i] != 0) n = i + 1;
            end
            for (int i = 0; i < 6; i++) o[i] = (i < n) ? code_tab[dig[i]] : 8'hFF;
            if (s && n < 6) o[n] = 8'hBF;
        end
        for (int i = 0; i < 6; i++) if (p[i]) o[i][7] = 1'b0;
        return o;
    endfunction

    // One clock: advance the model by the cycle count, then compare all outputs
    task automatic tick();
        logic       en_b;
        disp_t      disp_b;
        int         idx_b;
        logic [5:0] exp_sel;
        logic [7:0] exp_seg;
        en_b   = seg_en;
        disp_b = disp_m;
        idx_b  = (k / DWELL) % 6;
        @(posedge sys_clk);
        k++;
        if (k % PERIOD == 1) begin
            cap_d = data;
            cap_s = sign;
            cap_p = point;
        end
        if (k % PERIOD == 0) disp_m = build(cap_d, cap_s, cap_p);
        #1;
        check("conv_done", 32'(conv_done), 32'(k % PERIOD == 0));
        if (en_b) begin
            exp_sel = ~(6'b1 << idx_b);
            exp_seg = disp_b[idx_b];
        end else begin
            exp_sel = 6'h3F;
            exp_seg = 8'hFF;
        end
        check("sel", 32'(sel), 32'(exp_sel));
        check("seg", 32'(seg), 32'(exp_seg));
    endtask

    task automatic release_reset();
        @(negedge sys_clk);
        sys_rst = 1'b0;
        k       = 0;
        disp_m  = '1;
    endtask

    task automatic rand_inputs();
        int mag;
        mag    = $urandom_range(0, 6);
        data   = 20'($urandom_range(0, lim_tab[mag]));
        sign   = 1'($urandom_range(0, 1));
        point  = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'h00;
    endtask

    initial begin
        logic [19:0] dir_d [8] = '{20'd123456, 20'd42, 20'd0, 20'd0, 20'd1000000, 20'd999999, 20'd7, 20'd100000};
        logic        dir_s [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [5:0]  dir_p [8] = '{6'h00, 6'h00, 6'h01, 6'h20, 6'h00, 6'h15, 6'h3F, 6'h00};

        sys_rst = 1'b1;
        data    = '0;
        point   = '0;
        sign    = 1'b0;
        seg_en  = 1'b1;
        cap_d   = '0;
        cap_s   = 1'b0;
        cap_p   = '0;
        k       = 0;
        disp_m  = '1;
        #1;
        check("rst_sel", 32'(sel), 32'h3F);
        check("rst_seg", 32'(seg), 32'hFF);
        check("rst_conv_done", 32'(conv_done), 32'h0);
        repeat (2) @(posedge sys_clk);
        release_reset();

        // Directed values, each held for three conversion periods (covers a full scan)
        for (int c = 0; c < 8; c++) begin
            data  = dir_d[c];
            sign  = dir_s[c];
            point = dir_p[c];
            for (int t = 0; t < 3 * PERIOD; t++) begin
                if (c == 0 && t == 34) seg_en = 1'b0;
                if (c == 0 && t == 37) seg_en = 1'b1;
                tick();
            end
        end

        // Random input churn, including changes during SHIFT/UPDATE and seg_en dropouts
        for (int t = 0; t < 900; t++) begin
            if ($urandom_range(0, 7) == 0) rand_inputs();
            seg_en = ($urandom_range(0, 15) != 0);
            tick();
        end

        // Asynchronous reset in the middle of SHIFT
        seg_en = 1'b1;
        while (k % PERIOD != 8) tick();
        #2;
        sys_rst = 1'b1;
        #1;
        check("midrst_sel", 32'(sel), 32'h3F);
        check("midrst_seg", 32'(seg), 32'hFF);
        check("midrst_conv_done", 32'(conv_done), 32'h0);
        release_reset();

        for (int t = 0; t < 900; t++) begin
            if ($urandom_range(0, 5) == 0) rand_inputs();
            seg_en = ($urandom_range(0, 19) != 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
